// File: rtl/sha3_pkg.sv
// Shared constants and FSM state type for the SHA3-256 block padder.
package sha3_pkg;
    localparam int unsigned RATE_BITS  = 1088;
    localparam int unsigned RATE_WORDS = 17;
    localparam int unsigned RATE_BYTES = 136;

    localparam logic [7:0] SHA3_DOMAIN_PAD = 8'h06;
    localparam logic [7:0] SHA3_FINAL_PAD  = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        SEND,
        PADBLK
    } state_t;
endpackage

// File: rtl/sha3_last_word_pad.sv
// Final-word handling: masks bytes >= n and inserts the 0x06 domain byte at byte n.
module sha3_last_word_pad #(
    parameter int unsigned WORD_W     = 64,
    parameter int unsigned LANE_W     = 5,
    parameter int unsigned RATE_WORDS = 17
) (
    input  logic [WORD_W-1:0] data,
    input  logic [3:0]        nbytes,
    input  logic [LANE_W-1:0] lane,
    output logic [WORD_W-1:0] word,
    output logic              spill,
    output logic              overflow
);
    import sha3_pkg::*;

    localparam int unsigned BYTES_PER_WORD = WORD_W / 8;

    int unsigned n;

    always_comb begin
        n = (nbytes > 4'd8) ? 8 : 32'(nbytes);
        word = '0;
        for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
            if (k < n)
                word[8*k +: 8] = data[8*k +: 8];
            else if (k == n)
                word[8*k +: 8] = SHA3_DOMAIN_PAD;
        end
        // A full final word pushes 0x06 into byte 0 of the next lane, or into a whole new block.
        spill    = (n == BYTES_PER_WORD) && (32'(lane) != RATE_WORDS - 1);
        overflow = (n == BYTES_PER_WORD) && (32'(lane) == RATE_WORDS - 1);
    end
endmodule

// File: rtl/sha3_padder.sv
// Assembles 64-bit message words into padded 1088-bit rate blocks for SHA3TOP.
module sha3_padder #(
    parameter int unsigned RATE_WORDS = 17,
    parameter int unsigned WORD_W     = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WORD_W-1:0]            s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    input  logic [3:0]                   s_bytes,
    output logic                         s_ready,
    output logic [RATE_WORDS*WORD_W-1:0] in_data,
    output logic                         in_valid,
    output logic                         more,
    input  logic                         hash_next
);
    import sha3_pkg::*;

    localparam int unsigned LANE_W = $clog2(RATE_WORDS);
    localparam int unsigned BLK_W  = RATE_WORDS * WORD_W;
    localparam logic [BLK_W-1:0] PAD_ONLY =
        {SHA3_FINAL_PAD, {(BLK_W-16){1'b0}}, SHA3_DOMAIN_PAD};

    state_t            state, state_next;
    logic [LANE_W-1:0] wcnt;
    logic              pending;
    logic              run;
    logic [BLK_W-1:0]  blk;
    logic [BLK_W-1:0]  blk_final;
    logic [WORD_W-1:0] last_word;
    logic              spill;
    logic              overflow;
    logic              xfer;
    logic              last_lane;
    logic [31:0]       lane_base;

    sha3_last_word_pad #(
        .WORD_W    (WORD_W),
        .LANE_W    (LANE_W),
        .RATE_WORDS(RATE_WORDS)
    ) u_last_pad (
        .data    (s_data),
        .nbytes  (s_bytes),
        .lane    (wcnt),
        .word    (last_word),
        .spill   (spill),
        .overflow(overflow)
    );

    // run holds s_ready low until the first edge after reset release.
    assign s_ready   = run && (state == FILL);
    assign xfer      = s_valid && s_ready;
    assign in_valid  = (state == SEND) && hash_next;
    assign in_data   = blk;
    assign last_lane = (wcnt == LANE_W'(RATE_WORDS - 1));
    assign lane_base = 32'(wcnt) * WORD_W;

    // Lanes above the current one are already zero because the buffer is cleared per block.
    always_comb begin
        blk_final = blk;
        blk_final[lane_base +: WORD_W] = last_word;
        if (spill)
            blk_final[lane_base + WORD_W +: 8] = SHA3_DOMAIN_PAD;
        if (!overflow)
            blk_final[BLK_W-1 -: 8] = blk_final[BLK_W-1 -: 8] | SHA3_FINAL_PAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (xfer && (s_last || last_lane)) state_next = SEND;
            SEND:    if (hash_next) state_next = pending ? PADBLK : FILL;
            PADBLK:  state_next = SEND;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk     <= '0;
            wcnt    <= '0;
            pending <= 1'b0;
            more    <= 1'b0;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                FILL: begin
                    if (xfer) begin
                        if (!s_last) begin
                            blk[lane_base +: WORD_W] <= s_data;
                            if (last_lane) begin
                                more <= 1'b1;
                                wcnt <= '0;
                            end else begin
                                wcnt <= wcnt + 1'b1;
                            end
                        end else begin
                            blk     <= blk_final;
                            more    <= overflow;
                            pending <= overflow;
                            wcnt    <= '0;
                        end
                    end
                end
                SEND: begin
                    if (hash_next && !pending)
                        blk <= '0;
                end
                PADBLK: begin
                    blk     <= PAD_ONLY;
                    more    <= 1'b0;
                    pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha3_padder.sv
// Directed-vector bench for sha3_padder with hand-computed block images.
module tb_sha3_padder;
    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   s_data;
    logic          s_valid;
    logic          s_last;
    logic [3:0]    s_bytes;
    logic          s_ready;
    logic [1087:0] in_data;
    logic          in_valid;
    logic          more;
    logic          hash_next;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pulses   = 0;
    logic        prev_iv  = 1'b0;

    localparam logic [1087:0] PAD_ONLY = {8'h80, 1072'd0, 8'h06};

    always #5 clk = ~clk;

    sha3_padder #(.RATE_WORDS(17), .WORD_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_bytes  (s_bytes),
        .s_ready  (s_ready),
        .in_data  (in_data),
        .in_valid (in_valid),
        .more     (more),
        .hash_next(hash_next)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_block(input string tag, input logic [1087:0] got, input logic [1087:0] exp);
        for (int i = 0; i < 17; i++)
            check($sformatf("%s.lane%0d", tag, i), got[64*i +: 64], exp[64*i +: 64]);
    endtask

    always @(negedge clk) begin
        if (prev_iv)
            check("no_back_to_back", {63'd0, in_valid}, 64'd0);
        if (in_valid)
            pulses++;
        prev_iv = in_valid;
    end

    function automatic logic [63:0] pat(input int i);
        return 64'h0101010101010101 * 64'(i + 1);
    endfunction

    task automatic push(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int unsigned cyc = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        s_bytes = nb;
        while (!s_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!s_ready)
            check("push_timeout", {63'd0, s_ready}, 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic get_block(output logic [1087:0] d, output logic m, output int unsigned cyc);
        cyc = 0;
        @(negedge clk);
        while (!in_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("pulse_seen", {63'd0, in_valid}, 64'd1);
        d = in_data;
        m = more;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1087:0] blk;
        logic [1087:0] e;
        logic          m;
        int unsigned   cyc;
        int unsigned   p0;

        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_bytes = '0; hash_next = 1'b0;
        #22;
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_in_valid", {63'd0, in_valid}, 64'd0);
        check("rst_more", {63'd0, more}, 64'd0);
        check_block("rst_in_data", in_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("s_ready_before_edge", {63'd0, s_ready}, 64'd0);
        @(posedge clk); #1;
        check("s_ready_after_release", {63'd0, s_ready}, 64'd1);
        hash_next = 1'b1;

        // Empty message
        push(64'd0, 1'b1, 4'd0);
        get_block(blk, m, cyc);
        check("empty_latency", 64'(cyc), 64'd0);
        check("empty_more", {63'd0, m}, 64'd0);
        check_block("empty", blk, PAD_ONLY);
        check("ready_after_pulse", {63'd0, s_ready}, 64'd1);
        check("cleared_after_pulse", in_data[63:0], 64'd0);

        // "abc"
        push(64'h0000_0000_0063_6261, 1'b1, 4'd3);
        get_block(blk, m, cyc);
        check("abc_low32", {32'd0, blk[31:0]}, 64'h0663_6261);
        e = '0; e[63:0] = 64'h0663_6261; e[1087 -: 8] = 8'h80;
        check_block("abc", blk, e);
        check("abc_more", {63'd0, m}, 64'd0);

        // 135 bytes: 16 full words plus 7
        for (int i = 0; i < 16; i++) push(pat(i), 1'b0, 4'd8);
        push(64'hA7A6A5A4A3A2A1A0, 1'b1, 4'd7);
        get_block(blk, m, cyc);
        e = '0;
        for (int i = 0; i < 16; i++) e[64*i +: 64] = pat(i);
        e[64*16 +: 64] = 64'h86A6A5A4A3A2A1A0;
        check_block("b135", blk, e);
        check("b135_more", {63'd0, m}, 64'd0);

        // 136 bytes: 17th word final and full
        for (int i = 0; i < 16; i++) push(pat(i), 1'b0, 4'd8);
        push(64'hA7A6A5A4A3A2A1A0, 1'b1, 4'd8);
        get_block(blk, m, cyc);
        e = '0;
        for (int i = 0; i < 16; i++) e[64*i +: 64] = pat(i);
        e[64*16 +: 64] = 64'hA7A6A5A4A3A2A1A0;
        check_block("b136_first", blk, e);
        check("b136_first_more", {63'd0, m}, 64'd1);
        get_block(blk, m, cyc);
        check("b136_gap", 64'(cyc), 64'd1);
        check_block("b136_pad", blk, PAD_ONLY);
        check("b136_pad_more", {63'd0, m}, 64'd0);

        // Full final word mid-block, s_bytes above 8 clamps to 8
        push(pat(0), 1'b0, 4'd8);
        push(pat(1), 1'b0, 4'd8);
        push(64'hA7A6A5A4A3A2A1A0, 1'b1, 4'd12);
        get_block(blk, m, cyc);
        e = '0;
        e[63:0] = pat(0); e[127:64] = pat(1); e[191:128] = 64'hA7A6A5A4A3A2A1A0;
        e[199:192] = 8'h06; e[1087 -: 8] = 8'h80;
        check_block("spill", blk, e);
        check("spill_more", {63'd0, m}, 64'd0);

        // Backpressure on a full non-final block
        hash_next = 1'b0;
        for (int i = 0; i < 17; i++) push(pat(i + 3), 1'b0, 4'd8);
        e = '0;
        for (int i = 0; i < 17; i++) e[64*i +: 64] = pat(i + 3);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("bp_in_valid", {63'd0, in_valid}, 64'd0);
            check("bp_s_ready", {63'd0, s_ready}, 64'd0);
            check("bp_stable_lane16", in_data[64*16 +: 64], pat(19));
        end
        @(posedge clk); #1;
        hash_next = 1'b1;
        p0 = pulses;
        get_block(blk, m, cyc);
        check("bp_latency", 64'(cyc), 64'd0);
        check("bp_more", {63'd0, m}, 64'd1);
        check_block("bp", blk, e);
        @(negedge clk);
        check("bp_one_pulse", 64'(pulses - p0), 64'd1);
        @(posedge clk); #1;
        push(64'd0, 1'b1, 4'd0);
        get_block(blk, m, cyc);
        check_block("bp_tail", blk, PAD_ONLY);
        check("bp_tail_more", {63'd0, m}, 64'd0);

        // Reset mid-fill
        for (int i = 0; i < 5; i++) push(pat(i), 1'b0, 4'd8);
        rst_n = 1'b0;
        #2;
        check("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("mid_rst_in_valid", {63'd0, in_valid}, 64'd0);
        check("mid_rst_more", {63'd0, more}, 64'd0);
        check_block("mid_rst_in_data", in_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(64'h61, 1'b1, 4'd1);
        get_block(blk, m, cyc);
        e = '0; e[15:0] = 16'h0661; e[1087 -: 8] = 8'h80;
        check_block("after_rst", blk, e);
        check("after_rst_more", {63'd0, m}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sha3_padder.md
# sha3_padder

Upstream feeder for the SHA3-256 core `SHA3TOP`. It accepts a message as a stream of 64-bit little-endian words and assembles 1088-bit rate blocks. It applies SHA3 domain padding (0x06 … 0x80) to the final block and issues each block to the core as a one-cycle `in_valid` pulse, with `more` flagging non-final blocks. It throttles the upstream source while a block waits for the core's `hash_next`.

## Interface

Parameters:
- `RATE_WORDS`, 17: 64-bit words per rate block (1088 bits, SHA3-256).
- `WORD_W`, 64: input word width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_data`  in  64  message word; byte k of the word is at bits [8k+7:8k].
- `s_valid`  in  1  word present.
- `s_last`  in  1  word is the final word of the message.
- `s_bytes`  in  4  valid bytes in a final word, 0..8. Ignored when `s_last`=0. Values >8 are treated as 8.
- `s_ready`  out  1  padder accepts a word this cycle (transfer = `s_valid & s_ready`).
- `in_data`  out  1088  block to the core; lane w at bits [64w+63:64w], block byte b at bits [8b+7:8b].
- `in_valid`  out  1  one-cycle block-issue pulse.
- `more`  out  1  1 = further blocks follow; 0 = final block. Valid with `in_valid`.
- `hash_next`  in  1  level from the core: high = core accepts a block this cycle. The core drops it the cycle after acceptance.

## Operation

- States: FILL, SEND, PADBLK.
- **FILL**
  - `s_ready`=1. Each transfer writes lane `wcnt`, where `wcnt` runs 0..16.
  - On a final word, bytes ≥ `s_bytes` are forced to 0.
- **Non-final word with `wcnt`=16:** block full. Set `more`=1, go to SEND.
- **Final word at lane w with n bytes:** pad position p = 8w+n, range 0..136.
  - p ≤ 135: XOR 0x06 into byte p and 0x80 into byte 135 (p=135 gives 0x86). Zero all bytes above p. Set `more`=0, go to SEND.
  - p = 136 (17 full words): set `more`=1, go to SEND, and record that a pad block is pending.
- **SEND**
  - `s_ready`=0. `in_data` is stable.
  - When `hash_next`=1: pulse `in_valid` for one cycle.
  - Next state:
    - pad block pending: PADBLK;
    - otherwise: FILL with `wcnt`=0, and the lane buffer is cleared at the same edge.
- **PADBLK**
  - Buffer loaded with byte0=0x06, byte135=0x80, all else 0, and `more`=0.
  - Returns to SEND with the pending flag cleared.
- `in_data` holds its value after the pulse until the buffer is next written.
- Empty message: `s_last`=1 with `s_bytes`=0 on the first word gives a single pad-only block.

## Timing

- Reset values: `s_ready`=0, `in_valid`=0, `more`=0, `in_data`=0, state FILL, `wcnt`=0, pending flag=0.
- `s_ready` rises in the first cycle after reset release.
- Block-complete word accepted at edge t:
  - `in_valid` is high in cycle t+1 at the earliest, when `hash_next` is already high;
  - otherwise `in_valid` is high in the first cycle in which `hash_next`=1.
- `s_ready` returns to 1 in the cycle after the pulse. Throughput is 17 words plus at least one issue cycle per block.
- PADBLK costs 1 cycle. The second pulse comes ≥2 cycles after the first, gated on `hash_next`.
- `in_valid` never stays high for two consecutive cycles.
- Reset asserted mid-message: partial block and pending flag are discarded immediately. The next message starts at lane 0.
- `s_valid` in SEND/PADBLK is not accepted. `s_data` must be held by the source.

## Structure

- `sha3_pkg` holds:
  - `RATE_BITS`=1088, `RATE_WORDS`=17, `RATE_BYTES`=136;
  - `SHA3_DOMAIN_PAD`=8'h06, `SHA3_FINAL_PAD`=8'h80;
  - the state enum {FILL, SEND, PADBLK}.
- One combinational sub-module, `sha3_last_word_pad`, handles a single final word. It takes (`s_data`, n, lane index) and returns the masked word with 0x06 inserted, plus the p=136 overflow flag. The byte-135 OR is applied in the top.
- Everything else lives in `sha3_padder`: lane buffer, `wcnt`, FSM, pending flag.

## Test plan

- **Empty message:** first word has `s_last`=1, `s_bytes`=0 → one pulse, `more`=0, `in_data[7:0]`=8'h06, `in_data[1087:1080]`=8'h80, rest 0.
- **"abc":** `s_data`=64'h0000_0000_0063_6261, `s_bytes`=3 →
  - `in_data[31:0]`=32'h0663_6261, byte135=8'h80, `more`=0;
  - through `SHA3TOP`, out=3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- **135 bytes:** 16 full words, then last with `s_bytes`=7 → single block, byte135=8'h86, `more`=0.
- **136 bytes:** 17 full words, last with `s_bytes`=8 →
  - pulse 1: `more`=1, data unmodified;
  - pulse 2: byte0=06, byte135=80, `more`=0.
- **Backpressure:** full block with `hash_next`=0 for 30 cycles → `in_valid`=0, `s_ready`=0, `in_data` stable. Exactly one pulse in the first cycle `hash_next`=1.
- **Reset mid-fill:** after 5 words, pulse `rst_n` low → all outputs 0. Next 1-byte message (8'h61) produces byte0=61, byte1=06, byte135=80.
